axi4_burst_master: RTL and testbench

- Synthesizable AXI4 initiator: turns single read/write burst commands into AXI4 INCR bursts on a 64-bit, 32-bit-address, 5-bit-ID bus.
- Same bus geometry as our simulated DRAM responder, so it can drive it directly in test harnesses.
- Client side: command, write-data and read-data streams plus a completion response. One transaction outstanding at a time.

---
 rtl/axi4_burst_master.sv | 202 ++++++++++++++++++++
 tb/tb_axi4_burst_master.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_burst_master.sv
// AXI4 INCR burst initiator: one read or write command at a time,
// with client-side data streams and a single completion response.
module axi4_burst_master #(
    parameter logic [4:0] AXI_ID   = 5'd0,
    parameter bit         CHECK_4K = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_bits_write,
    input  logic [31:0] cmd_bits_addr,
    input  logic [7:0]  cmd_bits_len,
    input  logic        wdata_valid,
    output logic        wdata_ready,
    input  logic [63:0] wdata_bits_data,
    input  logic [7:0]  wdata_bits_strb,
    output logic        rdata_valid,
    input  logic        rdata_ready,
    output logic [63:0] rdata_bits_data,
    output logic        rdata_bits_last,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_bits_write,
    output logic [1:0]  resp_bits_resp,
    output logic        axi_aw_valid,
    input  logic        axi_aw_ready,
    output logic [31:0] axi_aw_bits_addr,
    output logic [7:0]  axi_aw_bits_len,
    output logic [2:0]  axi_aw_bits_size,
    output logic [1:0]  axi_aw_bits_burst,
    output logic        axi_aw_bits_lock,
    output logic [3:0]  axi_aw_bits_cache,
    output logic [2:0]  axi_aw_bits_prot,
    output logic [3:0]  axi_aw_bits_qos,
    output logic [3:0]  axi_aw_bits_region,
    output logic [4:0]  axi_aw_bits_id,
    output logic        axi_aw_bits_user,
    output logic        axi_w_valid,
    input  logic        axi_w_ready,
    output logic [63:0] axi_w_bits_data,
    output logic [7:0]  axi_w_bits_strb,
    output logic        axi_w_bits_last,
    output logic [4:0]  axi_w_bits_id,
    output logic        axi_w_bits_user,
    input  logic        axi_b_valid,
    output logic        axi_b_ready,
    input  logic [4:0]  axi_b_bits_id,
    input  logic [1:0]  axi_b_bits_resp,
    input  logic        axi_b_bits_user,
    output logic        axi_ar_valid,
    input  logic        axi_ar_ready,
    output logic [31:0] axi_ar_bits_addr,
    output logic [7:0]  axi_ar_bits_len,
    output logic [2:0]  axi_ar_bits_size,
    output logic [1:0]  axi_ar_bits_burst,
    output logic        axi_ar_bits_lock,
    output logic [3:0]  axi_ar_bits_cache,
    output logic [2:0]  axi_ar_bits_prot,
    output logic [3:0]  axi_ar_bits_qos,
    output logic [3:0]  axi_ar_bits_region,
    output logic [4:0]  axi_ar_bits_id,
    output logic        axi_ar_bits_user,
    input  logic        axi_r_valid,
    output logic        axi_r_ready,
    input  logic [63:0] axi_r_bits_data,
    input  logic [4:0]  axi_r_bits_id,
    input  logic [1:0]  axi_r_bits_resp,
    input  logic        axi_r_bits_last,
    input  logic        axi_r_bits_user
);

    typedef enum logic [2:0] {
        IDLE, AR, RDATA, AW, WDATA, BRESP, RESP
    } state_e;

    state_e      state_q;
    logic [31:0] addr_q;
    logic [7:0]  len_q;
    logic        write_q;
    logic [7:0]  count_q;
    logic [1:0]  resp_q;

    logic       last_beat;
    logic [9:0] span_d;
    logic       cross_d;
    logic [1:0] r_resp_d;
    logic       unused;

    assign last_beat = (count_q == len_q);
    assign span_d    = {1'b0, cmd_bits_addr[11:3]} + {2'b0, cmd_bits_len};
    assign cross_d   = CHECK_4K && (span_d > 10'd511);

    // Protocol violations on R override whatever has accumulated so far
    always_comb begin
        r_resp_d = (axi_r_bits_resp > resp_q) ? axi_r_bits_resp : resp_q;
        if ((axi_r_bits_id != AXI_ID) || (axi_r_bits_last != last_beat))
            r_resp_d = 2'b10;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            write_q <= 1'b0;
            count_q <= '0;
            resp_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: if (cmd_valid) begin
                    addr_q  <= {cmd_bits_addr[31:3], 3'b000};
                    len_q   <= cmd_bits_len;
                    write_q <= cmd_bits_write;
                    if (cross_d) begin
                        resp_q  <= 2'b10;
                        state_q <= RESP;
                    end else begin
                        state_q <= cmd_bits_write ? AW : AR;
                    end
                end
                AR: if (axi_ar_ready) state_q <= RDATA;
                AW: if (axi_aw_ready) state_q <= WDATA;
                RDATA: if (axi_r_valid && rdata_ready) begin
                    resp_q <= r_resp_d;
                    if (last_beat) begin
                        count_q <= '0;
                        state_q <= RESP;
                    end else begin
                        count_q <= count_q + 8'd1;
                    end
                end
                WDATA: if (wdata_valid && axi_w_ready) begin
                    if (last_beat) begin
                        count_q <= '0;
                        state_q <= BRESP;
                    end else begin
                        count_q <= count_q + 8'd1;
                    end
                end
                BRESP: if (axi_b_valid) begin
                    resp_q  <= (axi_b_bits_id != AXI_ID) ? 2'b10 : axi_b_bits_resp;
                    state_q <= RESP;
                end
                RESP: if (resp_ready) begin
                    resp_q  <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready    = !reset && (state_q == IDLE);
    assign axi_ar_valid = !reset && (state_q == AR);
    assign axi_aw_valid = !reset && (state_q == AW);
    assign axi_b_ready  = !reset && (state_q == BRESP);
    assign resp_valid   = !reset && (state_q == RESP);

    assign axi_w_valid  = !reset && (state_q == WDATA) && wdata_valid;
    assign wdata_ready  = !reset && (state_q == WDATA) && axi_w_ready;
    assign rdata_valid  = !reset && (state_q == RDATA) && axi_r_valid;
    assign axi_r_ready  = !reset && (state_q == RDATA) && rdata_ready;

    assign axi_w_bits_data = wdata_bits_data;
    assign axi_w_bits_strb = wdata_bits_strb;
    assign axi_w_bits_last = last_beat;
    assign axi_w_bits_id   = AXI_ID;
    assign axi_w_bits_user = 1'b0;

    assign rdata_bits_data = axi_r_bits_data;
    assign rdata_bits_last = last_beat;
    assign resp_bits_write = write_q;
    assign resp_bits_resp  = resp_q;

    assign axi_aw_bits_addr   = addr_q;
    assign axi_aw_bits_len    = len_q;
    assign axi_aw_bits_size   = 3'd3;
    assign axi_aw_bits_burst  = 2'b01;
    assign axi_aw_bits_lock   = 1'b0;
    assign axi_aw_bits_cache  = 4'd0;
    assign axi_aw_bits_prot   = 3'd0;
    assign axi_aw_bits_qos    = 4'd0;
    assign axi_aw_bits_region = 4'd0;
    assign axi_aw_bits_id     = AXI_ID;
    assign axi_aw_bits_user   = 1'b0;

    assign axi_ar_bits_addr   = addr_q;
    assign axi_ar_bits_len    = len_q;
    assign axi_ar_bits_size   = 3'd3;
    assign axi_ar_bits_burst  = 2'b01;
    assign axi_ar_bits_lock   = 1'b0;
    assign axi_ar_bits_cache  = 4'd0;
    assign axi_ar_bits_prot   = 3'd0;
    assign axi_ar_bits_qos    = 4'd0;
    assign axi_ar_bits_region = 4'd0;
    assign axi_ar_bits_id     = AXI_ID;
    assign axi_ar_bits_user   = 1'b0;

    assign unused = ^{cmd_bits_addr[2:0], axi_b_bits_user, axi_r_bits_user};

endmodule

// File: tb/tb_axi4_burst_master.sv
// Directed bench for axi4_burst_master: the bench acts as the AXI
// responder and client, with scoreboard queues for beats and responses.
module tb_axi4_burst_master;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_bits_write = 1'b0;
    logic [31:0] cmd_bits_addr = '0;
    logic [7:0]  cmd_bits_len = '0;
    logic        wdata_valid = 1'b0;
    logic        wdata_ready;
    logic [63:0] wdata_bits_data = '0;
    logic [7:0]  wdata_bits_strb = '0;
    logic        rdata_valid;
    logic        rdata_ready = 1'b0;
    logic [63:0] rdata_bits_data;
    logic        rdata_bits_last;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic        resp_bits_write;
    logic [1:0]  resp_bits_resp;
    logic        aw_valid, aw_ready = 1'b0;
    logic [31:0] aw_addr;
    logic [7:0]  aw_len;
    logic [2:0]  aw_size;
    logic [1:0]  aw_burst;
    logic        aw_lock;
    logic [3:0]  aw_cache;
    logic [2:0]  aw_prot;
    logic [3:0]  aw_qos, aw_region;
    logic [4:0]  aw_id;
    logic        aw_user;
    logic        w_valid, w_ready = 1'b0;
    logic [63:0] w_data;
    logic [7:0]  w_strb;
    logic        w_last;
    logic [4:0]  w_id;
    logic        w_user;
    logic        b_valid = 1'b0, b_ready;
    logic [4:0]  b_id = '0;
    logic [1:0]  b_resp = '0;
    logic        ar_valid, ar_ready = 1'b0;
    logic [31:0] ar_addr;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;
    logic        ar_lock;
    logic [3:0]  ar_cache;
    logic [2:0]  ar_prot;
    logic [3:0]  ar_qos, ar_region;
    logic [4:0]  ar_id;
    logic        ar_user;
    logic        r_valid = 1'b0, r_ready;
    logic [63:0] r_data = '0;
    logic [4:0]  r_id = '0;
    logic [1:0]  r_resp = '0;
    logic        r_last = 1'b0;

    axi4_burst_master #(.AXI_ID(5'd0), .CHECK_4K(1'b1)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_bits_write(cmd_bits_write), .cmd_bits_addr(cmd_bits_addr),
        .cmd_bits_len(cmd_bits_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
        .wdata_bits_data(wdata_bits_data), .wdata_bits_strb(wdata_bits_strb),
        .rdata_valid(rdata_valid), .rdata_ready(rdata_ready),
        .rdata_bits_data(rdata_bits_data), .rdata_bits_last(rdata_bits_last),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_bits_write(resp_bits_write), .resp_bits_resp(resp_bits_resp),
        .axi_aw_valid(aw_valid), .axi_aw_ready(aw_ready),
        .axi_aw_bits_addr(aw_addr), .axi_aw_bits_len(aw_len),
        .axi_aw_bits_size(aw_size), .axi_aw_bits_burst(aw_burst),
        .axi_aw_bits_lock(aw_lock), .axi_aw_bits_cache(aw_cache),
        .axi_aw_bits_prot(aw_prot), .axi_aw_bits_qos(aw_qos),
        .axi_aw_bits_region(aw_region), .axi_aw_bits_id(aw_id),
        .axi_aw_bits_user(aw_user),
        .axi_w_valid(w_valid), .axi_w_ready(w_ready),
        .axi_w_bits_data(w_data), .axi_w_bits_strb(w_strb),
        .axi_w_bits_last(w_last), .axi_w_bits_id(w_id),
        .axi_w_bits_user(w_user),
        .axi_b_valid(b_valid), .axi_b_ready(b_ready),
        .axi_b_bits_id(b_id), .axi_b_bits_resp(b_resp),
        .axi_b_bits_user(1'b0),
        .axi_ar_valid(ar_valid), .axi_ar_ready(ar_ready),
        .axi_ar_bits_addr(ar_addr), .axi_ar_bits_len(ar_len),
        .axi_ar_bits_size(ar_size), .axi_ar_bits_burst(ar_burst),
        .axi_ar_bits_lock(ar_lock), .axi_ar_bits_cache(ar_cache),
        .axi_ar_bits_prot(ar_prot), .axi_ar_bits_qos(ar_qos),
        .axi_ar_bits_region(ar_region), .axi_ar_bits_id(ar_id),
        .axi_ar_bits_user(ar_user),
        .axi_r_valid(r_valid), .axi_r_ready(r_ready),
        .axi_r_bits_data(r_data), .axi_r_bits_id(r_id),
        .axi_r_bits_resp(r_resp), .axi_r_bits_last(r_last),
        .axi_r_bits_user(1'b0)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    logic [64:0] rsb[$];
    logic [72:0] wsb[$];
    logic [2:0]  psb[$];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_cmd(input logic w, input logic [31:0] a,
                            input logic [7:0] l);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_bits_write = w;
        cmd_bits_addr = a;
        cmd_bits_len = l;
        #1;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        chk("cmd_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic get_resp(input string tag);
        int n = 0;
        logic [2:0] e;
        while (!resp_valid && n < 20) begin
            tick();
            n++;
        end
        e = (psb.size() > 0) ? psb.pop_front() : 3'bxxx;
        chk({tag, "_resp_valid"}, resp_valid, 1);
        chk({tag, "_resp"}, resp_bits_resp, e[1:0]);
        chk({tag, "_resp_write"}, resp_bits_write, e[2]);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk({tag, "_resp_drop"}, resp_valid, 0);
    endtask

    task automatic do_read(input string tag, input logic [31:0] a,
                           input logic [7:0] l, input logic [63:0] base,
                           input logic [15:0] rr, input logic [7:0] lm,
                           input bit toggle, input logic [1:0] exp_resp);
        int n = 0;
        int got = 0;
        int cyc = 0;
        bit done;
        logic [64:0] e;
        psb.push_back({1'b0, exp_resp});
        send_cmd(1'b0, a, l);
        while (!ar_valid && n < 10) begin
            tick();
            n++;
        end
        chk({tag, "_ar_valid"}, ar_valid, 1);
        chk({tag, "_ar_addr"}, ar_addr, {a[31:3], 3'b000});
        chk({tag, "_ar_len"}, ar_len, l);
        chk({tag, "_ar_size"}, ar_size, 3);
        ar_ready = 1'b1;
        tick();
        ar_ready = 1'b0;
        for (int b = 0; b <= int'(l); b++) begin
            r_valid = 1'b1;
            r_data = base + 64'(b);
            r_resp = rr[2*b +: 2];
            r_last = lm[b];
            r_id = 5'd0;
            rsb.push_back({b == int'(l), base + 64'(b)});
            done = 1'b0;
            while (!done && cyc < 100) begin
                rdata_ready = toggle ? ~rdata_ready : 1'b1;
                #1;
                if (rdata_valid && rdata_ready) begin
                    e = (rsb.size() > 0) ? rsb.pop_front() : 65'bx;
                    chk({tag, "_rdata"}, rdata_bits_data, e[63:0]);
                    chk({tag, "_rlast"}, rdata_bits_last, e[64]);
                    got++;
                    done = 1'b1;
                end
                tick();
                cyc++;
            end
        end
        r_valid = 1'b0;
        r_last = 1'b0;
        rdata_ready = 1'b0;
        chk({tag, "_beats"}, got, int'(l) + 1);
        chk({tag, "_sb_empty"}, rsb.size(), 0);
        get_resp(tag);
    endtask

    task automatic do_write(input string tag, input logic [31:0] a,
                            input logic [7:0] l, input int awdly,
                            input logic [63:0] strbs, input logic [1:0] br,
                            input logic [4:0] bid, input logic [1:0] exp_resp);
        int n = 0;
        int got = 0;
        int cyc = 0;
        bit done;
        logic [72:0] e;
        logic [63:0] d;
        psb.push_back({1'b1, exp_resp});
        send_cmd(1'b1, a, l);
        while (!aw_valid && n < 10) begin
            tick();
            n++;
        end
        chk({tag, "_aw_valid"}, aw_valid, 1);
        chk({tag, "_aw_size"}, aw_size, 3);
        chk({tag, "_aw_burst"}, aw_burst, 1);
        for (int i = 0; i < awdly; i++) begin
            chk({tag, "_aw_hold_valid"}, aw_valid, 1);
            chk({tag, "_aw_hold_addr"}, aw_addr, {a[31:3], 3'b000});
            chk({tag, "_aw_hold_len"}, aw_len, l);
            tick();
        end
        chk({tag, "_aw_addr"}, aw_addr, {a[31:3], 3'b000});
        chk({tag, "_aw_len"}, aw_len, l);
        aw_ready = 1'b1;
        tick();
        aw_ready = 1'b0;
        for (int b = 0; b <= int'(l); b++) begin
            d = 64'h11 * 64'(b + 1);
            wdata_valid = 1'b1;
            wdata_bits_data = d;
            wdata_bits_strb = strbs[8*b +: 8];
            w_ready = 1'b1;
            wsb.push_back({b == int'(l), strbs[8*b +: 8], d});
            done = 1'b0;
            while (!done && cyc < 100) begin
                #1;
                if (w_valid && wdata_ready) begin
                    e = (wsb.size() > 0) ? wsb.pop_front() : 73'bx;
                    chk({tag, "_wdata"}, w_data, e[63:0]);
                    chk({tag, "_wstrb"}, w_strb, e[71:64]);
                    chk({tag, "_wlast"}, w_last, e[72]);
                    got++;
                    done = 1'b1;
                end
                tick();
                cyc++;
            end
        end
        wdata_valid = 1'b0;
        w_ready = 1'b0;
        chk({tag, "_beats"}, got, int'(l) + 1);
        b_valid = 1'b1;
        b_resp = br;
        b_id = bid;
        n = 0;
        #1;
        while (!b_ready && n < 10) begin
            tick();
            n++;
        end
        chk({tag, "_b_ready"}, b_ready, 1);
        tick();
        b_valid = 1'b0;
        get_resp(tag);
    endtask

    initial begin
        int n;
        bit saw;
        tick();
        tick();
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_valids", {aw_valid, w_valid, ar_valid, rdata_valid,
                           resp_valid, wdata_ready, r_ready, b_ready}, 0);
        reset = 1'b0;
        #1;
        chk("rst_release_cmd_ready", cmd_ready, 1);
        tick();

        do_read("rd1", 32'h1000, 8'd3, 64'hA0, 16'h0000, 8'b1000, 0, 2'b00);
        do_write("wr1", 32'h2008, 8'd1, 0, 64'h0FFF, 2'b00, 5'd0, 2'b00);

        psb.push_back({1'b0, 2'b10});
        send_cmd(1'b0, 32'h0FF8, 8'd1);
        n = 0;
        saw = 1'b0;
        while (!resp_valid && n < 5) begin
            saw |= ar_valid;
            tick();
            n++;
        end
        chk("x4k_latency_ok", n < 2, 1);
        chk("x4k_no_ar", saw | ar_valid, 0);
        get_resp("x4k");

        do_read("x4k_edge", 32'h0FF8, 8'd0, 64'h55, 16'h0000, 8'b1, 0, 2'b00);
        do_read("rmax", 32'h2000, 8'd2, 64'hB0, 16'h002C, 8'b100, 0, 2'b11);
        do_read("rlast", 32'h2000, 8'd2, 64'hC0, 16'h002C, 8'b010, 0, 2'b10);
        do_read("rbp", 32'h1805, 8'd5, 64'hD0, 16'h0000, 8'b100000, 1, 2'b00);
        do_write("wbp", 32'h3000, 8'd3, 5, 64'hFFFFFFFF, 2'b00, 5'd0, 2'b00);
        do_write("bid", 32'h0040, 8'd0, 0, 64'hFF, 2'b00, 5'd3, 2'b10);

        send_cmd(1'b1, 32'h4000, 8'd7);
        n = 0;
        while (!aw_valid && n < 10) begin
            tick();
            n++;
        end
        aw_ready = 1'b1;
        tick();
        aw_ready = 1'b0;
        wdata_valid = 1'b1;
        wdata_bits_data = 64'h11;
        wdata_bits_strb = 8'hFF;
        w_ready = 1'b1;
        tick();
        wdata_bits_data = 64'h22;
        #1;
        chk("mid_w_valid", w_valid, 1);
        reset = 1'b1;
        wdata_valid = 1'b0;
        w_ready = 1'b0;
        tick();
        chk("mid_rst_valids", {aw_valid, w_valid, ar_valid, rdata_valid,
                               resp_valid, wdata_ready, r_ready, b_ready}, 0);
        chk("mid_rst_cmd_ready", cmd_ready, 0);
        tick();
        chk("mid_rst_cmd_ready2", cmd_ready, 0);
        reset = 1'b0;
        #1;
        chk("mid_rst_release", cmd_ready, 1);
        saw = 1'b0;
        for (int i = 0; i < 4; i++) begin
            saw |= resp_valid;
            tick();
        end
        chk("mid_rst_no_resp", saw | resp_valid, 0);

        do_read("post", 32'h5000, 8'd0, 64'hE0, 16'h0000, 8'b1, 0, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
